// File: rtl/demux18_tdm_pkg.sv
// demux18_tdm_pkg: shared constants and state encoding for the TDM
// demultiplexer (demux18_tdm) and its channel register (demux18_chan_reg).
package demux18_tdm_pkg;

  // Number of demultiplexed output channels and width of a channel index
  localparam int NUM_CH = 8;
  localparam int CH_W   = 3;

  // Frame receiver state
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_e;

  // Index of the channel that closes a frame
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

endpackage : demux18_tdm_pkg

// File: rtl/demux18_chan_reg.sv
// demux18_chan_reg: one width-bit channel register with load enable and
// asynchronous active-low clear. Used for both the visible outputs and,
// in the double-buffered build, the shadow copies.
import demux18_tdm_pkg::*;

module demux18_chan_reg #(
  parameter int width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [width-1:0] d_in,
  output logic [width-1:0] q_out
);

  logic [width-1:0] q_q;
  logic [width-1:0] q_d;

  // Next value: take the new word only when loading, otherwise hold
  always_comb begin
    q_d = q_q;
    if (load_en) begin
      q_d = d_in;
    end
  end

  // Storage flop, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_out = q_q;

endmodule : demux18_chan_reg

// File: rtl/demux18_tdm.sv
// demux18_tdm: receiving end of an 8:1 TDM word stream. Each accepted beat
// (CSn low and Data_Valid high) is written to the next channel register,
// starting at channel 0 on Frame_Start. Frame_Done pulses after channel 7,
// Frame_Err pulses when a new Frame_Start restarts an unfinished frame.
// Optional build macro DEMUX_DOUBLE_BUF_EN: beats collect in shadow
// registers and all outputs update together on frame completion, so an
// aborted frame never reaches the outputs.
import demux18_tdm_pkg::*;

module demux18_tdm #(
  parameter int width = 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             CSn,
  input  logic             Frame_Start,
  input  logic             Data_Valid,
  input  logic [width-1:0] Data_In,
  output logic [width-1:0] LED_Out0,
  output logic [width-1:0] LED_Out1,
  output logic [width-1:0] LED_Out2,
  output logic [width-1:0] LED_Out3,
  output logic [width-1:0] LED_Out4,
  output logic [width-1:0] LED_Out5,
  output logic [width-1:0] LED_Out6,
  output logic [width-1:0] LED_Out7,
  output logic [2:0]       Chan_Idx,
  output logic             Busy,
  output logic             Frame_Done,
  output logic             Frame_Err
);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   idx_q, idx_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [NUM_CH-1:0] wr_en;
  logic              accept;
  logic [width-1:0]  led [NUM_CH];

  assign accept = !CSn && Data_Valid;

  // Frame sequencing: pick the channel to write and the next state/status
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wr_en   = '0;
    if (accept) begin
      if (Frame_Start) begin
        // Start or restart: channel 0 always takes this beat
        wr_en[0] = 1'b1;
        idx_d    = CH_W'(1);
        state_d  = ST_RECV;
        err_d    = (state_q == ST_RECV);
      end else if (state_q == ST_RECV) begin
        wr_en[idx_q] = 1'b1;
        idx_d        = idx_q + CH_W'(1);
        if (idx_q == LAST_CH) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
    end
  end

  // FSM, channel counter and registered status pulses
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
`ifdef DEMUX_DOUBLE_BUF_EN
    logic [width-1:0] shd_q;
    logic [width-1:0] commit_data;

    // The closing beat bypasses its shadow so it commits in the same edge
    assign commit_data = wr_en[gi] ? Data_In : shd_q;

    demux18_chan_reg #(.width(width)) u_shd (
      .clk    (Clk),
      .rst_n  (Rst_n),
      .load_en(wr_en[gi]),
      .d_in   (Data_In),
      .q_out  (shd_q)
    );

    demux18_chan_reg #(.width(width)) u_out (
      .clk    (Clk),
      .rst_n  (Rst_n),
      .load_en(done_d),
      .d_in   (commit_data),
      .q_out  (led[gi])
    );
`else
    demux18_chan_reg #(.width(width)) u_out (
      .clk    (Clk),
      .rst_n  (Rst_n),
      .load_en(wr_en[gi]),
      .d_in   (Data_In),
      .q_out  (led[gi])
    );
`endif
  end

  assign LED_Out0   = led[0];
  assign LED_Out1   = led[1];
  assign LED_Out2   = led[2];
  assign LED_Out3   = led[3];
  assign LED_Out4   = led[4];
  assign LED_Out5   = led[5];
  assign LED_Out6   = led[6];
  assign LED_Out7   = led[7];
  assign Chan_Idx   = idx_q;
  assign Busy       = (state_q == ST_RECV);
  assign Frame_Done = done_q;
  assign Frame_Err  = err_q;

endmodule : demux18_tdm

// File: tb/tb_demux18_tdm.sv
// tb_demux18_tdm: directed bench for demux18_tdm (width=5) with a frame-level
// reference model, a per-cycle compare process and literal spot checks.
// Honours DEMUX_DOUBLE_BUF_EN when the design is built with it.
module tb_demux18_tdm;

  localparam int W = 5;

  logic         Clk = 1'b0;
  logic         Rst_n;
  logic         CSn;
  logic         Frame_Start;
  logic         Data_Valid;
  logic [W-1:0] Data_In;
  logic [W-1:0] LED_Out0, LED_Out1, LED_Out2, LED_Out3;
  logic [W-1:0] LED_Out4, LED_Out5, LED_Out6, LED_Out7;
  logic [2:0]   Chan_Idx;
  logic         Busy;
  logic         Frame_Done;
  logic         Frame_Err;

  demux18_tdm #(.width(W)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .CSn        (CSn),
    .Frame_Start(Frame_Start),
    .Data_Valid (Data_Valid),
    .Data_In    (Data_In),
    .LED_Out0   (LED_Out0),
    .LED_Out1   (LED_Out1),
    .LED_Out2   (LED_Out2),
    .LED_Out3   (LED_Out3),
    .LED_Out4   (LED_Out4),
    .LED_Out5   (LED_Out5),
    .LED_Out6   (LED_Out6),
    .LED_Out7   (LED_Out7),
    .Chan_Idx   (Chan_Idx),
    .Busy       (Busy),
    .Frame_Done (Frame_Done),
    .Frame_Err  (Frame_Err)
  );

  always #5 Clk = ~Clk;

  logic [W-1:0] dut_led [8];
  assign dut_led[0] = LED_Out0;
  assign dut_led[1] = LED_Out1;
  assign dut_led[2] = LED_Out2;
  assign dut_led[3] = LED_Out3;
  assign dut_led[4] = LED_Out4;
  assign dut_led[5] = LED_Out5;
  assign dut_led[6] = LED_Out6;
  assign dut_led[7] = LED_Out7;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frame position counted in beats since Frame_Start
  logic [W-1:0] m_led [8];
  logic [W-1:0] m_shd [8];
  int           m_pos;
  bit           m_recv;
  bit           m_done;
  bit           m_err;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_led[i] = '0;
      m_shd[i] = '0;
    end
    m_pos  = 0;
    m_recv = 0;
    m_done = 0;
    m_err  = 0;
  endtask

  task automatic model_step(input logic cs, input logic fs, input logic dv, input logic [W-1:0] d);
    int ch;
    ch     = -1;
    m_done = 0;
    m_err  = 0;
    if (!cs && dv) begin
      if (fs) begin
        m_err  = m_recv;
        ch     = 0;
        m_recv = 1;
        m_pos  = 1;
      end else if (m_recv) begin
        ch = m_pos;
        m_pos++;
        if (m_pos == 8) begin
          m_pos  = 0;
          m_recv = 0;
          m_done = 1;
        end
      end
    end
    if (ch >= 0) begin
`ifdef DEMUX_DOUBLE_BUF_EN
      m_shd[ch] = d;
      if (m_done) m_led = m_shd;
`else
      m_led[ch] = d;
`endif
    end
  endtask

  // Per-cycle comparison against the model, plus pulse bookkeeping
  int done_cnt = 0;
  int err_cnt  = 0;
  int cyc      = 0;
  int done_cyc [$];

  always @(negedge Clk) begin
    cyc++;
    for (int i = 0; i < 8; i++) chk($sformatf("led%0d", i), 32'(dut_led[i]), 32'(m_led[i]));
    chk("chan_idx", 32'(Chan_Idx), 32'(m_pos % 8));
    chk("busy", 32'(Busy), 32'(m_recv));
    chk("frame_done", 32'(Frame_Done), 32'(m_done));
    chk("frame_err", 32'(Frame_Err), 32'(m_err));
    if (Frame_Done === 1'b1) begin
      done_cnt++;
      done_cyc.push_back(cyc);
    end
    if (Frame_Err === 1'b1) err_cnt++;
  end

  // One clock of stimulus; ends 1 time unit after the active edge
  task automatic step(input logic cs, input logic fs, input logic dv, input logic [W-1:0] d);
    CSn         = cs;
    Frame_Start = fs;
    Data_Valid  = dv;
    Data_In     = d;
    @(posedge Clk);
    model_step(cs, fs, dv, d);
    #1;
  endtask

  task automatic beat(input logic fs, input logic [W-1:0] d);
    step(1'b0, fs, 1'b1, d);
  endtask

  // Asynchronous reset between edges, checked before the next edge
  task automatic async_reset();
    #2;
    Rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_led0", 32'(LED_Out0), 32'h0);
    chk("rst_led7", 32'(LED_Out7), 32'h0);
    chk("rst_idx", 32'(Chan_Idx), 32'h0);
    chk("rst_busy", 32'(Busy), 32'h0);
    step(1'b1, 1'b0, 1'b0, '0);
    Rst_n = 1'b1;
  endtask

  initial begin
    Rst_n = 1'b0;
    CSn = 1'b1; Frame_Start = 1'b0; Data_Valid = 1'b0; Data_In = '0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    chk("init_busy", 32'(Busy), 32'h0);
    chk("init_idx", 32'(Chan_Idx), 32'h0);

    // Beat without Frame_Start while idle is discarded
    beat(1'b0, 5'h1F);
    chk("idle_discard_led0", 32'(LED_Out0), 32'h0);

    // Full frame 1..8
    beat(1'b1, 5'd1);
    for (int k = 2; k <= 8; k++) beat(1'b0, W'(k));
    chk("full_done_pulse", 32'(Frame_Done), 32'h1);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("full_led0", 32'(LED_Out0), 32'd1);
    chk("full_led3", 32'(LED_Out3), 32'd4);
    chk("full_led7", 32'(LED_Out7), 32'd8);
    chk("full_idx", 32'(Chan_Idx), 32'd0);
    chk("full_busy", 32'(Busy), 32'd0);
    chk("full_done_cnt", 32'(done_cnt), 32'd1);

    // Same frame shape with Data_Valid gaps and CSn-high beats (17..24)
    beat(1'b1, 5'd17);
    beat(1'b0, 5'd18);
    beat(1'b0, 5'd19);
    step(1'b0, 1'b0, 1'b0, 5'h1E);
    step(1'b0, 1'b0, 1'b0, 5'h1E);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b1, 5'h1F);
    chk("gap_idx", 32'(Chan_Idx), 32'd3);
    for (int k = 20; k <= 24; k++) beat(1'b0, W'(k));
    step(1'b1, 1'b0, 1'b0, '0);
    chk("gap_led0", 32'(LED_Out0), 32'd17);
    chk("gap_led3", 32'(LED_Out3), 32'd20);
    chk("gap_led7", 32'(LED_Out7), 32'd24);
    chk("gap_done_cnt", 32'(done_cnt), 32'd2);
    chk("gap_err_cnt", 32'(err_cnt), 32'd0);

    // Abort: A,B,C,D then restart with E, then 7 beats 1..7
    beat(1'b1, 5'd10);
    beat(1'b0, 5'd11);
    beat(1'b0, 5'd12);
    beat(1'b0, 5'd13);
    beat(1'b1, 5'd14);
    chk("abort_err_pulse", 32'(Frame_Err), 32'h1);
    chk("abort_idx", 32'(Chan_Idx), 32'd1);
`ifdef DEMUX_DOUBLE_BUF_EN
    chk("abort_led0", 32'(LED_Out0), 32'd17);
    chk("abort_led1", 32'(LED_Out1), 32'd18);
`else
    chk("abort_led0", 32'(LED_Out0), 32'd14);
    chk("abort_led1", 32'(LED_Out1), 32'd11);
    chk("abort_led3", 32'(LED_Out3), 32'd13);
`endif
    for (int k = 1; k <= 6; k++) beat(1'b0, W'(k));
    chk("abort_no_done_yet", 32'(done_cnt), 32'd2);
    beat(1'b0, 5'd7);
    chk("abort_done_pulse", 32'(Frame_Done), 32'h1);
    chk("abort_led0_final", 32'(LED_Out0), 32'd14);
    chk("abort_led7_final", 32'(LED_Out7), 32'd7);

    // Back-to-back frames 1..8 and 9..16, no idle cycle
    for (int k = 1; k <= 16; k++) beat((k == 1) || (k == 9), W'(k));
    step(1'b0, 1'b0, 1'b0, '0);
    chk("b2b_done_cnt", 32'(done_cnt), 32'd5);
    chk("b2b_err_cnt", 32'(err_cnt), 32'd1);
    chk("b2b_gap", 32'(done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2]), 32'd8);
    chk("b2b_led0", 32'(LED_Out0), 32'd9);
    chk("b2b_led7", 32'(LED_Out7), 32'd16);

    // Reset mid-frame loses the partial frame
    beat(1'b1, 5'd3);
    beat(1'b0, 5'd4);
    beat(1'b0, 5'd5);
    async_reset();
    beat(1'b0, 5'd6);
    chk("post_rst_led1", 32'(LED_Out1), 32'h0);
    chk("post_rst_busy", 32'(Busy), 32'h0);

    step(1'b1, 1'b0, 1'b0, '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_demux18_tdm

// File: doc/demux18_tdm.md
Name: demux18_tdm

Overview:
- Receiving end of the 8:1 key/LED multiplexer path.
- Takes a time-multiplexed word stream (one channel per valid beat, channel 0 first) and demultiplexes it into eight held output registers.
- Frame control, channel counting and frame-complete/error status make it the sequential counterpart of the combinational 8:1 selector.
- Sits between a TDM source, such as a mux81 driven by a scanning counter, and the board LEDs or downstream logic.

Parameters:
- width, 1, bit width of each data word and each output channel.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- CSn  input  1  chip select, active low. When high, all inputs are ignored and state is frozen.
- Frame_Start  input  1  marks the beat carrying channel 0. Only meaningful together with Data_Valid.
- Data_Valid  input  1  the current Data_In beat is valid.
- Data_In  input  width  incoming multiplexed word.
- LED_Out0..LED_Out7  output  width each  demultiplexed channel registers.
- Chan_Idx  output  3  channel the next accepted beat will be written to.
- Busy  output  1  high while in state RECV.
- Frame_Done  output  1  one-cycle pulse after channel 7 is accepted.
- Frame_Err  output  1  one-cycle pulse when a frame is aborted by a new Frame_Start.

Behaviour:
- Reset (Rst_n low, asynchronous): state=IDLE; Chan_Idx=0; all LED_Out*=0; Busy=0; Frame_Done=0; Frame_Err=0; shadow registers (if present)=0.
- Accept condition: accept = !CSn & Data_Valid. With CSn high, nothing changes except that Frame_Done/Frame_Err return to 0.
- IDLE:
  - accept & Frame_Start: write Data_In to channel 0; Chan_Idx<=1; go to RECV.
  - accept & !Frame_Start: beat discarded; no status change.
- RECV:
  - accept & !Frame_Start: write Data_In to channel Chan_Idx; Chan_Idx<=Chan_Idx+1, wrapping 7->0.
  - If the written channel was 7: Frame_Done=1 next cycle; go to IDLE.
  - accept & Frame_Start: abort the current frame; Frame_Err=1 next cycle; the beat is written to channel 0; Chan_Idx<=1; stay in RECV. This is a restart, not a drop.
  - Data_Valid low: hold state.
- Latency: the written output register reflects Data_In one clock after the accept edge.
- Frame_Done and Frame_Err are single-cycle pulses and are never high in the same cycle.
- Back-to-back frames: Frame_Start on the beat immediately after channel 7 is accepted normally. The IDLE transition and the new channel-0 write coexist, so zero gap cycles are required.
- Unwritten channels of an aborted frame keep their previous values.
- Reset mid-frame clears everything immediately; the partial frame is lost.
- Busy = (state==RECV).

Optional Feature:
- Macro: DEMUX_DOUBLE_BUF_EN.
- Defined:
  - Accepted words go to eight shadow registers.
  - All LED_Out* update together from the shadows in the same cycle that Frame_Done pulses.
  - An aborted frame never reaches the outputs.
- Undefined: each LED_Out* updates individually one cycle after its beat, as described above.
- Status port behaviour is identical in both builds.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE=1'b0, ST_RECV=1'b1;
  - NUM_CH=8;
  - CH_W=3.
- One natural sub-module, demux18_chan_reg: a width-bit register with load enable and asynchronous active-low clear, instantiated eight times (sixteen with DEMUX_DOUBLE_BUF_EN).
- The FSM and channel counter stay in the top.

Test Plan:
- Reset: Rst_n=0 mid-run with outputs loaded -> all LED_Out*=0, Chan_Idx=0, Busy=0 asynchronously, before the next Clk edge.
- Full frame, width=4: Frame_Start with 8 consecutive valid beats 4'h1..4'h8 -> LED_Out0..7=1..8, each one cycle after its beat; Frame_Done pulses once after beat 8; Busy falls; Chan_Idx=0.
- Gaps and CSn: same frame with Data_Valid low for 2 cycles between beats 3 and 4, and CSn high for 3 cycles with Data_Valid high -> identical final outputs; the beats under CSn high are not counted.
- Abort: 4 beats A,B,C,D, then Frame_Start with E -> Frame_Err pulse; LED_Out0=E; LED_Out1..3 still B,C,D until rewritten; Frame_Done only after 7 more beats.
- Back-to-back: two frames with no idle cycle (values 1..8 then 9..16) -> two Frame_Done pulses 8 beats apart; final outputs 9..16; no Frame_Err.
- DEMUX_DOUBLE_BUF_EN build: repeat the full-frame scenario -> LED_Out* stay at old values until the Frame_Done cycle, then all update to 1..8 together. Aborted frame -> outputs unchanged.
